// File: rtl/trap_controller.sv
// trap_controller
//   Machine-mode trap sequencer between the pipeline and the CSR file.
//   Prioritises memory-stage exceptions over fetch-stage exceptions, then
//   interrupts, then MRET. Drains the pipeline via FLUSH/PIPE_EMPTY, then
//   pulses TRAP_TAKE (or RET_TAKE) for one cycle with the trap data.
//
// Ports
//   CLK, RST               clock, synchronous active-high reset
//   F_IAM/F_IAF/F_II       fetch-stage exceptions
//   ECALL/EBREAK           environment call / breakpoint (memory stage)
//   MEM_LAM/LAF/SAM/SAF    load/store misaligned / access fault
//   PRIVILEGE              current privilege level
//   F_PC/F_TVAL            fetch-stage PC and trap value
//   MEM_PC/MEM_TVAL        memory-stage PC and trap value
//   IRQ/MIE_MASK/GIE       interrupt requests, per-line and global enables
//   RESUME_PC              oldest uncommitted PC (interrupt EPC)
//   MTVEC/MEPC             CSR values
//   MRET/PIPE_EMPTY        MRET request, pipeline drained
//   FLUSH/BUSY             drain request, controller not idle
//   TRAP_TAKE/RET_TAKE     one-cycle trap-entry / return pulses
//   CAUSE/EPC/TVAL/REDIRECT_PC  registered trap data
//
// Configuration macro
//   VECTORED_MODE_EN : when defined, interrupts with MTVEC[1:0]==1 target
//                      base + 4*code; otherwise every trap targets base.

module trap_controller #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NUM_IRQ = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               F_IAM,
  input  logic               F_IAF,
  input  logic               F_II,
  input  logic               ECALL,
  input  logic               EBREAK,
  input  logic               MEM_LAM,
  input  logic               MEM_LAF,
  input  logic               MEM_SAM,
  input  logic               MEM_SAF,
  input  logic [1:0]         PRIVILEGE,
  input  logic [XLEN-1:0]    F_PC,
  input  logic [XLEN-1:0]    MEM_PC,
  input  logic [XLEN-1:0]    F_TVAL,
  input  logic [XLEN-1:0]    MEM_TVAL,
  input  logic [NUM_IRQ-1:0] IRQ,
  input  logic [NUM_IRQ-1:0] MIE_MASK,
  input  logic               GIE,
  input  logic [XLEN-1:0]    RESUME_PC,
  input  logic [XLEN-1:0]    MTVEC,
  input  logic [XLEN-1:0]    MEPC,
  input  logic               MRET,
  input  logic               PIPE_EMPTY,
  output logic               FLUSH,
  output logic               BUSY,
  output logic               TRAP_TAKE,
  output logic               RET_TAKE,
  output logic [XLEN-1:0]    CAUSE,
  output logic [XLEN-1:0]    EPC,
  output logic [XLEN-1:0]    TVAL,
  output logic [XLEN-1:0]    REDIRECT_PC
);

  localparam int unsigned IW = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_ENTER, S_RETURN} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   redir_q, redir_d;
  logic              irq_q, irq_d;

  logic              exc_valid, exc_mem;
  logic [4:0]        exc_code;
  logic [NUM_IRQ-1:0] irq_pend;
  logic              irq_valid;
  logic [XLEN-1:0]   irq_code;
  logic [XLEN-1:0]   irq_cause;
  logic [XLEN-1:0]   base;
  logic [XLEN-1:0]   irq_target;

  // Memory stage holds the older instruction, so its group wins over fetch.
  always_comb begin
    exc_valid = 1'b1;
    exc_mem   = 1'b1;
    exc_code  = 5'd0;
    if (EBREAK)       exc_code = 5'd3;
    else if (ECALL)   exc_code = 5'd8 + {3'b000, PRIVILEGE};
    else if (MEM_LAM) exc_code = 5'd4;
    else if (MEM_LAF) exc_code = 5'd5;
    else if (MEM_SAM) exc_code = 5'd6;
    else if (MEM_SAF) exc_code = 5'd7;
    else begin
      exc_mem = 1'b0;
      if (F_IAF)      exc_code = 5'd1;
      else if (F_II)  exc_code = 5'd2;
      else if (F_IAM) exc_code = 5'd0;
      else            exc_valid = 1'b0;
    end
  end

  // Ascending scan: the last pending bit seen is the highest index.
  always_comb begin
    irq_pend  = GIE ? (IRQ & MIE_MASK) : '0;
    irq_valid = |irq_pend;
    irq_code  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (irq_pend[i[IW-1:0]]) irq_code = XLEN'(i);
    end
    irq_cause = {1'b1, irq_code[XLEN-2:0]};
  end

  assign base = {MTVEC[XLEN-1:2], 2'b00};

`ifdef VECTORED_MODE_EN
  assign irq_target = (MTVEC[1:0] == 2'b01) ? base + (irq_code << 2) : base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^MTVEC[1:0];
  assign irq_target = base;
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    redir_d = redir_q;
    irq_d   = irq_q;
    case (state_q)
      S_IDLE: begin
        if (exc_valid) begin
          cause_d = XLEN'(exc_code);
          epc_d   = exc_mem ? MEM_PC : F_PC;
          tval_d  = exc_mem ? MEM_TVAL : F_TVAL;
          redir_d = base;
          irq_d   = 1'b0;
          state_d = S_FLUSH;
        end else if (irq_valid) begin
          cause_d = irq_cause;
          tval_d  = '0;
          redir_d = irq_target;
          irq_d   = 1'b1;
          state_d = S_FLUSH;
        end else if (MRET) begin
          redir_d = MEPC;
          state_d = S_RETURN;
        end
      end
      S_FLUSH: begin
        if (PIPE_EMPTY) begin
          // Interrupt EPC is the resume point once the pipe is drained.
          if (irq_q) epc_d = RESUME_PC;
          state_d = S_ENTER;
        end
      end
      S_ENTER:  state_d = S_IDLE;
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      redir_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      redir_q <= redir_d;
      irq_q   <= irq_d;
    end
  end

  assign FLUSH       = (state_q == S_FLUSH);
  assign BUSY        = (state_q != S_IDLE);
  assign TRAP_TAKE   = (state_q == S_ENTER);
  assign RET_TAKE    = (state_q == S_RETURN);
  assign CAUSE       = cause_q;
  assign EPC         = epc_q;
  assign TVAL        = tval_q;
  assign REDIRECT_PC = redir_q;

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned NUM_IRQ = 16;

  logic clk, rst;
  logic f_iam, f_iaf, f_ii, ecall, ebreak;
  logic mem_lam, mem_laf, mem_sam, mem_saf;
  logic [1:0] priv;
  logic [XLEN-1:0] f_pc, mem_pc, f_tval, mem_tval, resume_pc, mtvec, mepc;
  logic [NUM_IRQ-1:0] irq, mie;
  logic gie, mret, pipe_empty;
  logic flush, busy, trap_take, ret_take;
  logic [XLEN-1:0] cause, epc, tval, redirect_pc;

  int tests_run = 0;
  int tests_failed = 0;

  trap_controller #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
    .CLK(clk), .RST(rst),
    .F_IAM(f_iam), .F_IAF(f_iaf), .F_II(f_ii),
    .ECALL(ecall), .EBREAK(ebreak),
    .MEM_LAM(mem_lam), .MEM_LAF(mem_laf), .MEM_SAM(mem_sam), .MEM_SAF(mem_saf),
    .PRIVILEGE(priv),
    .F_PC(f_pc), .MEM_PC(mem_pc), .F_TVAL(f_tval), .MEM_TVAL(mem_tval),
    .IRQ(irq), .MIE_MASK(mie), .GIE(gie),
    .RESUME_PC(resume_pc), .MTVEC(mtvec), .MEPC(mepc),
    .MRET(mret), .PIPE_EMPTY(pipe_empty),
    .FLUSH(flush), .BUSY(busy), .TRAP_TAKE(trap_take), .RET_TAKE(ret_take),
    .CAUSE(cause), .EPC(epc), .TVAL(tval), .REDIRECT_PC(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    {f_iam, f_iaf, f_ii, ecall, ebreak} = '0;
    {mem_lam, mem_laf, mem_sam, mem_saf} = '0;
    irq = '0;
    mret = 1'b0;
  endtask

  task automatic randomize_inputs();
    int p;
    f_iam = ($urandom_range(0, 5) == 0);
    f_iaf = ($urandom_range(0, 5) == 0);
    f_ii = ($urandom_range(0, 5) == 0);
    ecall = ($urandom_range(0, 7) == 0);
    ebreak = ($urandom_range(0, 9) == 0);
    mem_lam = ($urandom_range(0, 7) == 0);
    mem_laf = ($urandom_range(0, 7) == 0);
    mem_sam = ($urandom_range(0, 7) == 0);
    mem_saf = ($urandom_range(0, 7) == 0);
    p = $urandom_range(0, 2);
    priv = (p == 2) ? 2'd3 : 2'(p);
    f_pc = {$urandom, $urandom};
    mem_pc = {$urandom, $urandom};
    f_tval = {$urandom, $urandom};
    mem_tval = {$urandom, $urandom};
    resume_pc = {$urandom, $urandom};
    mtvec = {$urandom, $urandom};
    mepc = {$urandom, $urandom};
    irq = NUM_IRQ'($urandom);
    mie = NUM_IRQ'($urandom);
    gie = $urandom_range(0, 1) == 1;
    mret = $urandom_range(0, 1) == 1;
  endtask

  // Reference: kind 0=none, 1=exception, 2=interrupt, 3=mret.
  // Exceptions are looked up in a priority table; interrupts pick the
  // highest enabled line; interrupt EPC is filled in by the caller.
  task automatic model(output int kind, output logic [XLEN-1:0] m_cause,
                       output logic [XLEN-1:0] m_epc, output logic [XLEN-1:0] m_tval,
                       output logic [XLEN-1:0] m_redir);
    logic flags[9];
    int   codes[9];
    logic [XLEN-1:0] b;
    logic [NUM_IRQ-1:0] pend;
    flags = '{ebreak, ecall, mem_lam, mem_laf, mem_sam, mem_saf, f_iaf, f_ii, f_iam};
    codes = '{3, 8 + int'(priv), 4, 5, 6, 7, 1, 2, 0};
    b = mtvec & ~64'h3;
    kind = 0; m_cause = '0; m_epc = '0; m_tval = '0; m_redir = '0;
    for (int k = 0; k < 9; k++) begin
      if (kind == 0 && flags[k]) begin
        kind = 1;
        m_cause = XLEN'(codes[k]);
        m_epc = (k < 6) ? mem_pc : f_pc;
        m_tval = (k < 6) ? mem_tval : f_tval;
        m_redir = b;
      end
    end
    pend = gie ? (irq & mie) : '0;
    if (kind == 0 && pend != 0) begin
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
        if (kind == 0 && pend[k]) begin
          kind = 2;
          m_cause = 64'h8000_0000_0000_0000 + 64'(k);
          m_redir = b;
`ifdef VECTORED_MODE_EN
          if (mtvec[1:0] == 2'b01) m_redir = b + 64'(4 * k);
`endif
        end
      end
    end
    if (kind == 0 && mret) begin
      kind = 3;
      m_redir = mepc;
    end
  endtask

  task automatic test_reset();
    randomize_inputs();
    rst = 1'b1;
    pipe_empty = 1'b1;
    step();
    step();
    tests_run++;
    if ({flush, busy, trap_take, ret_take} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags got %b exp 0000", {flush, busy, trap_take, ret_take});
    end
    tests_run++;
    if ({cause, epc, tval, redirect_pc} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data got %h/%h/%h/%h exp all zero", cause, epc, tval, redirect_pc);
    end
    rst = 1'b0;
    clear_events();
    step();
  endtask

  task automatic test_exception_routing();
    clear_events();
    f_ii = 1'b1; f_pc = 64'h100; f_tval = 64'h13;
    mtvec = 64'h8000; pipe_empty = 1'b1;
    step();
    tests_run++;
    if ({flush, busy} !== 2'b11) begin
      tests_failed++;
      $display("FAIL exc_flush got %b exp 11", {flush, busy});
    end
    clear_events();
    step();
    tests_run++;
    if (trap_take !== 1'b1 || cause !== 64'd2 || epc !== 64'h100 ||
        tval !== 64'h13 || redirect_pc !== 64'h8000) begin
      tests_failed++;
      $display("FAIL exc_route got take=%b cause=%h epc=%h tval=%h pc=%h exp 1/2/100/13/8000",
               trap_take, cause, epc, tval, redirect_pc);
    end
    step();
    tests_run++;
    if ({trap_take, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL exc_done got %b exp 00", {trap_take, busy});
    end
  endtask

  task automatic test_simultaneous();
    int takes;
    clear_events();
    mem_laf = 1'b1; mem_pc = 64'h200; mem_tval = 64'h777;
    f_iam = 1'b1; f_pc = 64'h104; f_tval = 64'h55;
    irq = 16'h0800; mie = '1; gie = 1'b1;
    mtvec = 64'h8000; pipe_empty = 1'b1;
    step();
    clear_events();
    takes = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (trap_take === 1'b1) begin
        takes++;
        tests_run++;
        if (cause !== 64'd5 || epc !== 64'h200 || tval !== 64'h777) begin
          tests_failed++;
          $display("FAIL simul_data got cause=%h epc=%h tval=%h exp 5/200/777", cause, epc, tval);
        end
      end
    end
    tests_run++;
    if (takes != 1) begin
      tests_failed++;
      $display("FAIL simul_count got %0d exp 1", takes);
    end
  endtask

  task automatic test_vectored_irq();
    int flush_cycles;
    logic [XLEN-1:0] exp_pc;
    clear_events();
    irq = 16'h0880; mie = 16'h0880; gie = 1'b1;
    mtvec = 64'h8001; pipe_empty = 1'b0; resume_pc = 64'h500;
`ifdef VECTORED_MODE_EN
    exp_pc = 64'h802C;
`else
    exp_pc = 64'h8000;
`endif
    step();
    irq = '0;
    flush_cycles = 0;
    for (int c = 0; c < 8; c++) begin
      if (flush === 1'b1) flush_cycles++;
      pipe_empty = (c >= 3);
      if (trap_take !== 1'b1) step();
    end
    tests_run++;
    if (flush_cycles != 4) begin
      tests_failed++;
      $display("FAIL vec_flush_len got %0d exp 4", flush_cycles);
    end
    tests_run++;
    if (trap_take !== 1'b1 || cause !== 64'h8000_0000_0000_000B ||
        epc !== 64'h500 || tval !== '0 || redirect_pc !== exp_pc) begin
      tests_failed++;
      $display("FAIL vec_irq got take=%b cause=%h epc=%h tval=%h pc=%h exp 1/800000000000000b/500/0/%h",
               trap_take, cause, epc, tval, redirect_pc, exp_pc);
    end
    step();
  endtask

  task automatic test_masking_mret();
    clear_events();
    gie = 1'b0; irq = '1; mie = '1; pipe_empty = 1'b1;
    step();
    tests_run++;
    if ({flush, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mask_gie got %b exp 00", {flush, busy});
    end
    mret = 1'b1; mepc = 64'h240;
    step();
    tests_run++;
    if (ret_take !== 1'b1 || redirect_pc !== 64'h240 || trap_take !== 1'b0) begin
      tests_failed++;
      $display("FAIL mret_take got ret=%b trap=%b pc=%h exp 1/0/240", ret_take, trap_take, redirect_pc);
    end
    clear_events();
    step();
    tests_run++;
    if ({ret_take, busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mret_done got %b exp 00", {ret_take, busy});
    end
  endtask

  task automatic test_reset_mid_flush();
    clear_events();
    ecall = 1'b1; priv = 2'd0; mem_pc = 64'h300; pipe_empty = 1'b0;
    step();
    clear_events();
    rst = 1'b1; pipe_empty = 1'b1;
    step();
    tests_run++;
    if ({flush, busy, trap_take} !== 3'b000 || cause !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid got flags=%b cause=%h exp 000/0", {flush, busy, trap_take}, cause);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (trap_take !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_no_take got %b exp 0", trap_take);
    end
    ecall = 1'b1; priv = 2'd3;
    step();
    clear_events();
    step();
    tests_run++;
    if (trap_take !== 1'b1 || cause !== 64'd11 || epc !== 64'h300) begin
      tests_failed++;
      $display("FAIL ecall_m got take=%b cause=%h epc=%h exp 1/b/300", trap_take, cause, epc);
    end
    step();
  endtask

  task automatic test_back_to_back();
    clear_events();
    mem_sam = 1'b1; mem_pc = 64'h400; mem_tval = 64'h404;
    mtvec = 64'h9000; pipe_empty = 1'b1;
    step();
    clear_events();
    step();
    tests_run++;
    if (trap_take !== 1'b1 || cause !== 64'd6) begin
      tests_failed++;
      $display("FAIL b2b_first got take=%b cause=%h exp 1/6", trap_take, cause);
    end
    f_iaf = 1'b1; f_pc = 64'h600; f_tval = 64'h601;
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle got busy=%b exp 0", busy);
    end
    step();
    clear_events();
    tests_run++;
    if (flush !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept got flush=%b exp 1", flush);
    end
    step();
    tests_run++;
    if (trap_take !== 1'b1 || cause !== 64'd1 || epc !== 64'h600 || tval !== 64'h601) begin
      tests_failed++;
      $display("FAIL b2b_second got take=%b cause=%h epc=%h tval=%h exp 1/1/600/601",
               trap_take, cause, epc, tval);
    end
    step();
  endtask

  task automatic test_random();
    int kind, wait_cycles;
    logic [XLEN-1:0] m_cause, m_epc, m_tval, m_redir;
    for (int n = 0; n < 80; n++) begin
      randomize_inputs();
      if ($urandom_range(0, 2) == 0) begin
        {f_iam, f_iaf, f_ii, ecall, ebreak, mem_lam, mem_laf, mem_sam, mem_saf} = '0;
      end
      pipe_empty = $urandom_range(0, 1) == 1;
      model(kind, m_cause, m_epc, m_tval, m_redir);
      step();
      if (kind == 0) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL rnd_none it=%0d got busy=%b exp 0", n, busy);
        end
      end else if (kind == 3) begin
        randomize_inputs();
        tests_run++;
        if (ret_take !== 1'b1 || redirect_pc !== m_redir) begin
          tests_failed++;
          $display("FAIL rnd_mret it=%0d got ret=%b pc=%h exp 1/%h", n, ret_take, redirect_pc, m_redir);
        end
        clear_events();
        step();
      end else begin
        wait_cycles = $urandom_range(0, 3);
        for (int w = 0; w < wait_cycles; w++) begin
          randomize_inputs();
          pipe_empty = 1'b0;
          step();
        end
        randomize_inputs();
        pipe_empty = 1'b1;
        if (kind == 2) m_epc = resume_pc;
        tests_run++;
        if (flush !== 1'b1) begin
          tests_failed++;
          $display("FAIL rnd_flush it=%0d got %b exp 1", n, flush);
        end
        step();
        tests_run++;
        if (trap_take !== 1'b1 || cause !== m_cause || epc !== m_epc ||
            tval !== m_tval || redirect_pc !== m_redir) begin
          tests_failed++;
          $display("FAIL rnd_trap it=%0d got take=%b cause=%h epc=%h tval=%h pc=%h exp 1/%h/%h/%h/%h",
                   n, trap_take, cause, epc, tval, redirect_pc, m_cause, m_epc, m_tval, m_redir);
        end
        clear_events();
        step();
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_events();
    priv = 2'd3; gie = 1'b0; mie = '0; pipe_empty = 1'b0;
    f_pc = '0; mem_pc = '0; f_tval = '0; mem_tval = '0;
    resume_pc = '0; mtvec = '0; mepc = '0;
    test_reset();
    test_exception_routing();
    test_simultaneous();
    test_vectored_irq();
    test_masking_mret();
    test_reset_mid_flush();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
# trap_controller

Parametrised machine-mode trap controller sitting between the pipeline and the CSR file. It prioritises synchronous exceptions from fetch and memory stages against a configurable interrupt vector. It drains the pipeline through a flush handshake, then emits a single-cycle trap-entry pulse carrying cause, EPC, TVAL and target PC. It also sequences MRET redirects.

## Interface
- XLEN, 64: datapath width; legal values 32 or 64.
- NUM_IRQ, 16: interrupt lines; bit i maps to cause code i; legal range 12..32.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- F_IAM, F_IAF, F_II  in  1 each  fetch-stage exceptions (misaligned, access fault, illegal instruction).
- ECALL, EBREAK  in  1 each  environment call / breakpoint, flagged at the memory stage.
- MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF  in  1 each  load/store misaligned and access-fault exceptions.
- PRIVILEGE  in  2  current privilege level (0=U, 1=S, 3=M).
- F_PC, MEM_PC  in  XLEN  PC of the faulting instruction in each stage.
- F_TVAL, MEM_TVAL  in  XLEN  trap value for each stage.
- IRQ  in  NUM_IRQ  level-sensitive interrupt requests.
- MIE_MASK  in  NUM_IRQ  per-line enables from the CSR file.
- GIE  in  1  mstatus.MIE global enable.
- RESUME_PC  in  XLEN  PC of the oldest uncommitted instruction.
- MTVEC, MEPC  in  XLEN  current CSR values.
- MRET  in  1  MRET reached the memory stage.
- PIPE_EMPTY  in  1  pipeline fully drained.
- FLUSH  out  1  request the pipeline to kill in-flight instructions.
- BUSY  out  1  state is not IDLE.
- TRAP_TAKE  out  1  one-cycle trap-entry pulse; the CSR file writes mcause, mepc and mtval.
- RET_TAKE  out  1  one-cycle MRET pulse.
- CAUSE, EPC, TVAL, REDIRECT_PC  out  XLEN  registered values, valid while TRAP_TAKE or RET_TAKE is high.

## Operation
- States: IDLE, FLUSH, ENTER, RETURN.
- Events are sampled only in IDLE. Priority is exceptions > interrupts > MRET.
- Exception order (highest first):
  - Memory-stage group, because it holds the older instruction: EBREAK(3), ECALL(8+PRIVILEGE), MEM_LAM(4), MEM_LAF(5), MEM_SAM(6), MEM_SAF(7). EPC and TVAL are taken from MEM_PC/MEM_TVAL.
  - Fetch group: F_IAF(1), F_II(2), F_IAM(0). EPC and TVAL are taken from F_PC/F_TVAL.
- Interrupts:
  - pending = IRQ & MIE_MASK, gated by GIE.
  - The highest-index pending bit wins.
  - CAUSE = {1'b1, zero-extended code}; TVAL = 0.
  - EPC is RESUME_PC, sampled in the cycle PIPE_EMPTY is seen in FLUSH.
- IDLE, on exception or interrupt: latch CAUSE, EPC and TVAL, then go to FLUSH.
- IDLE, on MRET alone: REDIRECT_PC <= MEPC, then go to RETURN.
- FLUSH:
  - FLUSH=1.
  - Stay until PIPE_EMPTY=1, then go to ENTER.
  - New exceptions, IRQ changes and MRET are ignored; the latched cause is committed even if IRQ drops.
- ENTER: TRAP_TAKE=1 for exactly one cycle, then IDLE.
- RETURN: RET_TAKE=1 for exactly one cycle, then IDLE.
- Target PC: base = {MTVEC[XLEN-1:2], 2'b00}.
  - Default: REDIRECT_PC = base.
  - Vectored (see Configuration): interrupt with MTVEC[1:0]==1 gives REDIRECT_PC = base + 4*code, modulo 2^XLEN.
- Reset values: FLUSH, BUSY, TRAP_TAKE, RET_TAKE = 0; CAUSE, EPC, TVAL, REDIRECT_PC = 0; state IDLE.

## Timing
- Event seen in IDLE at edge t: FLUSH and BUSY are high from t+1.
- PIPE_EMPTY sampled high at edge t+k: TRAP_TAKE is high during cycle t+k+1. Minimum trap latency is 2 cycles (PIPE_EMPTY already high at t+1).
- MRET at edge t: RET_TAKE during cycle t+1; IDLE at t+2.
- A new event may be accepted in the cycle after TRAP_TAKE or RET_TAKE (back-to-back traps allowed).
- RST high at any edge: IDLE and reset values on that edge. A pending TRAP_TAKE or RET_TAKE is never emitted.
- PIPE_EMPTY is ignored outside FLUSH.

## Configuration
- VECTORED_MODE_EN:
  - Defined: vectored interrupt targets, as in Operation.
  - Undefined: MTVEC[1:0] is ignored and every trap goes to base.

## Test plan
- Exception routing: F_II=1, F_PC=0x100, F_TVAL=0x13, PIPE_EMPTY=1, MTVEC=0x8000 -> TRAP_TAKE 2 cycles later with CAUSE=2, EPC=0x100, TVAL=0x13, REDIRECT_PC=0x8000.
- Simultaneous sources: MEM_LAF, F_IAM and IRQ[11] (enabled, GIE=1) in one cycle -> CAUSE=5, EPC=MEM_PC; a single TRAP_TAKE.
- Vectored interrupt with drain wait: IRQ[7] and IRQ[11] both enabled, MTVEC=0x8001 (VECTORED_MODE_EN defined), PIPE_EMPTY low for 3 cycles -> FLUSH high for 4 cycles; CAUSE=0x8000_0000_0000_000B (XLEN=64); REDIRECT_PC=0x802C. IRQ deasserted mid-flush still yields the trap.
- Masking: GIE=0 with IRQ all ones -> no FLUSH. Then MRET=1, MEPC=0x240 -> RET_TAKE next cycle with REDIRECT_PC=0x240.
- Reset mid-operation: RST asserted during FLUSH -> next cycle FLUSH=0, BUSY=0, no TRAP_TAKE. ECALL at PRIVILEGE=3 afterwards -> CAUSE=11.
